// File: rtl/wavetable_voice_scheduler_pkg.sv
// wavetable_voice_scheduler_pkg: shared widths and FSM state encodings for the voice scheduler
package wavetable_voice_scheduler_pkg;
    localparam int PHASE_W  = 32;
    localparam int ADDR_W   = 16;
    localparam int SAMPLE_W = 16;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_ACCUM = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
endpackage

// File: rtl/wavetable_voice_scheduler_voice_regfile.sv
// voice_regfile: per-voice tuning word, phase accumulator and enable storage
//   clk, rst           clock, asynchronous active-high reset
//   cfg_*              config write port (inc, enable, optional phase clear)
//   rd_voice           voice selected for reading and stepping
//   rd_addr, rd_en     top phase bits and enable of the selected voice
//   step               advance the selected voice's phase by its tuning word
module voice_regfile
    import wavetable_voice_scheduler_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int VOICE_BITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [VOICE_BITS-1:0] cfg_voice,
    input  logic [PHASE_W-1:0]    cfg_inc,
    input  logic                  cfg_en,
    input  logic                  cfg_phase_clr,
    input  logic [VOICE_BITS-1:0] rd_voice,
    output logic [ADDR_W-1:0]     rd_addr,
    output logic                  rd_en,
    input  logic                  step
);
    logic [PHASE_W-1:0]    phase [NUM_VOICES];
    logic [PHASE_W-1:0]    inc   [NUM_VOICES];
    logic [NUM_VOICES-1:0] en;

    assign rd_addr = phase[rd_voice][PHASE_W-1 -: ADDR_W];
    assign rd_en   = en[rd_voice];

    // The config write is placed after the step so that, for the same voice,
    // a phase clear overrides the increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= '{default: '0};
            inc   <= '{default: '0};
            en    <= '0;
        end else begin
            if (step)
                phase[rd_voice] <= phase[rd_voice] + inc[rd_voice];
            if (cfg_we) begin
                inc[cfg_voice] <= cfg_inc;
                en[cfg_voice]  <= cfg_en;
                if (cfg_phase_clr)
                    phase[cfg_voice] <= '0;
            end
        end
    end
endmodule

// File: rtl/wavetable_voice_scheduler.sv
// wavetable_voice_scheduler: shares one synchronous wavetable among voices and mixes one sample per tick
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_tick              sample-rate strobe starting a frame
//   i_cfg_*             voice config write (inc, enable, phase clear)
//   o_addr, i_data      wavetable address out, signed sample in
//   o_sample(_valid)    averaged mix and its one-cycle strobe
//   o_busy, o_overrun   frame in progress, sticky dropped-tick flag
module wavetable_voice_scheduler
    import wavetable_voice_scheduler_pkg::*;
#(
    parameter int NUM_VOICES  = 4,
    parameter int VOICE_BITS  = 2,
    parameter int ROM_LATENCY = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_tick,
    input  logic                  i_cfg_we,
    input  logic [VOICE_BITS-1:0] i_cfg_voice,
    input  logic [PHASE_W-1:0]    i_cfg_inc,
    input  logic                  i_cfg_en,
    input  logic                  i_cfg_phase_clr,
    output logic [ADDR_W-1:0]     o_addr,
    input  logic [SAMPLE_W-1:0]   i_data,
    output logic [SAMPLE_W-1:0]   o_sample,
    output logic                  o_sample_valid,
    output logic                  o_busy,
    output logic                  o_overrun
);
    localparam int ACC_W = SAMPLE_W + VOICE_BITS;

    logic [2:0]            state;
    logic [VOICE_BITS-1:0] v;
    logic [2:0]            wcnt;
    logic [ACC_W-1:0]      acc;
    logic                  en_lat;
    logic                  rd_en;
    logic [ADDR_W-1:0]     rd_addr;

    voice_regfile #(.NUM_VOICES(NUM_VOICES), .VOICE_BITS(VOICE_BITS)) u_regs (
        .clk          (i_clk),
        .rst          (i_rst),
        .cfg_we       (i_cfg_we),
        .cfg_voice    (i_cfg_voice),
        .cfg_inc      (i_cfg_inc),
        .cfg_en       (i_cfg_en),
        .cfg_phase_clr(i_cfg_phase_clr),
        .rd_voice     (v),
        .rd_addr      (rd_addr),
        .rd_en        (rd_en),
        .step         (state == S_ISSUE && rd_en)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state          <= S_IDLE;
            v              <= '0;
            wcnt           <= '0;
            acc            <= '0;
            en_lat         <= 1'b0;
            o_addr         <= '0;
            o_sample       <= '0;
            o_sample_valid <= 1'b0;
            o_busy         <= 1'b0;
            o_overrun      <= 1'b0;
        end else begin
            o_sample_valid <= 1'b0;
            if (i_tick && state != S_IDLE)
                o_overrun <= 1'b1;
            case (state)
                S_IDLE: if (i_tick) begin
                    acc    <= '0;
                    v      <= '0;
                    o_busy <= 1'b1;
                    state  <= S_ISSUE;
                end
                S_ISSUE: begin
                    // Enable is latched here so a later config write cannot
                    // change whether this voice's returning sample is used.
                    en_lat <= rd_en;
                    if (rd_en)
                        o_addr <= rd_addr;
                    wcnt  <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    wcnt <= wcnt + 3'd1;
                    if (wcnt == 3'(ROM_LATENCY - 1))
                        state <= S_ACCUM;
                end
                S_ACCUM: begin
                    if (en_lat)
                        acc <= acc + {{VOICE_BITS{i_data[SAMPLE_W-1]}}, i_data};
                    if (v == VOICE_BITS'(NUM_VOICES - 1))
                        state <= S_DONE;
                    else begin
                        v     <= v + VOICE_BITS'(1);
                        state <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    // Dropping the low bits is an arithmetic shift by VOICE_BITS.
                    o_sample       <= acc[ACC_W-1:VOICE_BITS];
                    o_sample_valid <= 1'b1;
                    o_busy         <= 1'b0;
                    state          <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
